// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_arbiter
// Brief    : 8237-style DMA request qualification, HRQ/HLDA handshake and
//            fixed/rotating channel priority. Optional macro PRIORITY_STATUS_EN
//            adds the reqStatus output.
// Revision : 1.0
// ============================================================================
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              rotatingPriority,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [1:0]        activeChannel,
    output logic              channelValid,
`ifdef PRIORITY_STATUS_EN
    output logic [NUM_CH-1:0] reqStatus,
`endif
    output logic [NUM_CH-1:0] swReqClear
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_hrq;
    logic              r_valid;
    logic [1:0]        r_active;
    logic [1:0]        r_lastServed;
    logic [NUM_CH-1:0] r_swClr;
    logic [NUM_CH-1:0] r_dack;

    logic [NUM_CH-1:0] w_effReq;
    logic              w_anyReq;
    logic [1:0]        w_base;
    logic [1:0]        w_idx;
    logic [1:0]        w_winner;
    logic [1:0]        w_nextActive;
    logic [NUM_CH-1:0] w_swClr;
    logic [NUM_CH-1:0] w_dackAct;
    logic              w_updPtr;
    logic              w_grantNext;

    // Priority scan runs from lowest to highest so the highest-priority hit wins.
    always_comb begin
        w_effReq = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg;
        w_anyReq = |w_effReq;
        w_base   = rotatingPriority ? (r_lastServed + 2'd1) : 2'd0;
        w_winner = w_base;
        w_idx    = w_base;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = w_base + 2'(i);
            if (w_effReq[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_nextActive = r_active;
        w_swClr      = '0;
        w_updPtr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_anyReq && !controllerDisable) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (HLDA) begin
                    if (w_anyReq) begin
                        w_next       = S_GRANT;
                        w_nextActive = w_winner;
                    end else begin
                        w_next = S_RELEASE;
                    end
                end else if (!w_anyReq) begin
                    w_next = S_IDLE;
                end
            end
            S_GRANT: begin
                // serviceDone wins over a simultaneous HLDA drop
                if (serviceDone) begin
                    w_next            = S_RELEASE;
                    w_swClr[r_active] = 1'b1;
                    w_updPtr          = rotatingPriority;
                end else if (!HLDA) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!HLDA) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_grantNext = (w_next == S_GRANT);
        w_dackAct   = '0;
        if (w_grantNext) begin
            w_dackAct[w_nextActive] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_hrq        <= 1'b0;
            r_valid      <= 1'b0;
            r_active     <= 2'd0;
            r_swClr      <= '0;
            r_dack       <= dackSenseHigh ? '0 : '1;
            r_lastServed <= 2'd3;
        end else begin
            r_state  <= w_next;
            r_hrq    <= (w_next == S_REQ) || (w_next == S_GRANT);
            r_valid  <= w_grantNext;
            r_active <= w_nextActive;
            r_swClr  <= w_swClr;
            r_dack   <= dackSenseHigh ? w_dackAct : ~w_dackAct;
            if (w_updPtr) begin
                r_lastServed <= r_active;
            end
        end
    end

`ifdef PRIORITY_STATUS_EN
    logic [NUM_CH-1:0] r_reqStatus;

    // Software bit drops together with its swReqClear pulse; a live DREQ keeps it set.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_reqStatus <= '0;
        end else begin
            r_reqStatus <= (DREQ ^ {NUM_CH{dreqSenseLow}}) | (requestReg & ~w_swClr);
        end
    end

    assign reqStatus = r_reqStatus;
`endif

    assign HRQ           = r_hrq;
    assign DACK          = r_dack;
    assign activeChannel = r_active;
    assign channelValid  = r_valid;
    assign swReqClear    = r_swClr;

endmodule
`default_nettype wire
